map_rom_arbiter: RTL and testbench
==================================

MAP_ROM_ARBITER -- requirements
Module: map_rom_arbiter

Interface
REQ-001 Parameter WIDTH, default 30, is the map row width in bits (one bit per tile column).
REQ-002 Parameter DEPTH, default 21, is the number of map rows.
REQ-003 Parameter ADDRW, default $clog2(DEPTH), is the row address width.
REQ-004 Parameter MAX_WAIT, default 8, is the number of consecutive denied cycles after which the game requester is forced a grant.
REQ-005 clk  input  1  is the single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset  input  1  is the asynchronous, active-low reset.
REQ-007 vga_req  input  1  is the renderer's row-read request, sampled every cycle, with no grant returned.
REQ-008 vga_addr  input  ADDRW  is the renderer row address.
REQ-009 vga_valid  output  1  is a one-cycle pulse marking vga_data valid.
REQ-010 vga_data  output  WIDTH  is the row data returned to the renderer.
REQ-011 vga_miss  output  1  is a one-cycle pulse when a sampled vga_req was not served.
REQ-012 game_req  input  1  is the game-logic row-read request, held high until granted.
REQ-013 game_addr  input  ADDRW  is the game row address, held stable while game_req is high.
REQ-014 game_gnt  output  1  is a one-cycle grant pulse.
REQ-015 game_valid  output  1  is a one-cycle pulse marking game_data valid.
REQ-016 game_data  output  WIDTH  is the row data returned to the game logic.
REQ-017 addr_err  output  1  is a one-cycle pulse with the valid strobe of a read whose address was >= DEPTH.
REQ-018 rom_addr  output  ADDRW  drives the single-port map ROM (one-cycle synchronous read).
REQ-019 rom_data  input  WIDTH  is the ROM read data, valid one cycle after rom_addr is registered.

Function
REQ-020 The FSM SHALL have three states, IDLE, SERVE_VGA and SERVE_GAME, with the state updated every edge from that cycle's sampled requests.
REQ-021 Next-state selection SHALL be:
  - starved: game_req high and wait_cnt == MAX_WAIT-1 -> SERVE_GAME;
  - else vga_req high -> SERVE_VGA;
  - else game_req high -> SERVE_GAME;
  - else IDLE.
REQ-022 wait_cnt SHALL increment on each edge where game_req is high and not granted; it SHALL clear on grant or when game_req is low, and it SHALL saturate at MAX_WAIT-1.
REQ-023 On a grant edge, rom_addr SHALL register the winner's address, and a 2-bit owner tag plus an error bit (addr >= DEPTH) SHALL be registered.
REQ-024 game_gnt SHALL pulse high for exactly the one cycle following the granting edge; the game requester SHALL drop or change game_req/game_addr only after seeing game_gnt.
REQ-025 Latency SHALL be fixed at two edges from the sampling edge to vga_valid or game_valid.
REQ-026 Data and valid routing:
  - The data/valid stage SHALL register rom_data into the tagged owner's data output.
  - Only that owner's valid SHALL be asserted, for one cycle.
  - The other owner's data SHALL hold its last value.
REQ-027 An out-of-range read SHALL return all-zero data with addr_err asserted.
REQ-028 vga_miss SHALL pulse one cycle after an edge where vga_req was high but SERVE_GAME was chosen (starvation override).
REQ-029 Throughput SHALL be one read per cycle, fully pipelined, with back-to-back grants allowed.
REQ-030 Simultaneous requests SHALL resolve as follows: without starvation VGA wins; with starvation the game wins and vga_miss pulses.
REQ-031 vga_valid and game_valid SHALL never be high in the same cycle.

Reset
REQ-032 While reset is low:
  - state SHALL be IDLE;
  - wait_cnt, owner tag and error bit SHALL be 0;
  - rom_addr SHALL be 0;
  - all valid, gnt, miss and err outputs SHALL be 0;
  - vga_data and game_data SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight reads, producing no valid pulse after release.
REQ-034 The first grant SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-035 MAP_WIDTH (30), MAP_DEPTH (21), TILE_SIZE (20) and the owner-tag encodings SHALL live in a shared game constants package.
REQ-036 The map ROM instance SHALL remain outside this block; the arbiter SHALL only drive and consume its ports.
REQ-037 One sub-module, starve_counter (the saturating wait_cnt with its terminal flag), is natural; all other logic SHALL be flat.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
  - Reset: hold reset low, toggle requests -> all outputs 0; after release, vga_req with addr 5 -> vga_valid 2 cycles later with vga_data = ROM row 5.
  - VGA only: vga_req streaming addrs 0..20 -> vga_valid every cycle, data in order, game_gnt never asserted.
  - Contention/starvation: vga_req held continuously, game_req with addr 7 -> game_gnt on the 8th cycle of waiting, one vga_miss pulse, game_data = row 7 two cycles after grant, vga stream resumes.
  - Idle game: vga_req low, game_req with addr 3 -> game_gnt next cycle, game_valid after 2 cycles, wait_cnt back to 0.
  - Out of range: game_addr 25 -> game_data = 0 with addr_err pulsing alongside game_valid.
  - Reset mid-flight: reset asserted one cycle after a grant -> no valid pulse after release, state IDLE.

Source files
------------

// File: rtl/map_rom_arbiter_pkg.sv
// Shared game constants plus the arbiter's state and owner-tag encodings.
package map_rom_arbiter_pkg;

    localparam int MAP_WIDTH = 30;
    localparam int MAP_DEPTH = 21;
    localparam int TILE_SIZE = 20;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_GAME = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_VGA  = 2'd1,
        SERVE_GAME = 2'd2
    } arb_state_e;

    // The serving state doubles as the first-stage owner tag of the read pipeline.
    function automatic owner_e owner_of(input arb_state_e s);
        case (s)
            SERVE_VGA:  return OWN_VGA;
            SERVE_GAME: return OWN_GAME;
            default:    return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/map_rom_arbiter_starve_counter.sv
// Counts consecutive denied game-request edges, saturating at MAX_WAIT-1;
// starved_o flags the terminal count.
module map_rom_arbiter_starve_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic game_req_i,
    input  logic grant_i,
    output logic starved_o
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign starved_o = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (!game_req_i || grant_i) begin
            cnt_d = '0;
        end else if (!starved_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/map_rom_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous map ROM:
// grant edge -> ROM read edge -> data/valid edge, one read per cycle.
module map_rom_arbiter
    import map_rom_arbiter_pkg::*;
#(
    parameter int WIDTH    = MAP_WIDTH,
    parameter int DEPTH    = MAP_DEPTH,
    parameter int ADDRW    = $clog2(DEPTH),
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vga_req_i,
    input  logic [ADDRW-1:0] vga_addr_i,
    output logic             vga_valid_o,
    output logic [WIDTH-1:0] vga_data_o,
    output logic             vga_miss_o,
    input  logic             game_req_i,
    input  logic [ADDRW-1:0] game_addr_i,
    output logic             game_gnt_o,
    output logic             game_valid_o,
    output logic [WIDTH-1:0] game_data_o,
    output logic             addr_err_o,
    output logic [ADDRW-1:0] rom_addr_o,
    input  logic [WIDTH-1:0] rom_data_i
);

    localparam logic [ADDRW:0] DEPTH_W = (ADDRW + 1)'(DEPTH);

    arb_state_e       state_q, state_d;
    logic             cnt_term;
    logic             starved;
    logic [ADDRW-1:0] win_addr;
    logic             win_oor;
    logic [ADDRW-1:0] rom_addr_q;
    logic             err0_q;
    owner_e           tag_q;
    logic             err_q;
    logic             game_gnt_q, vga_miss_q;
    logic             vga_valid_q, game_valid_q, addr_err_q;
    logic [WIDTH-1:0] vga_data_q, game_data_q;

    map_rom_arbiter_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .game_req_i (game_req_i),
        .grant_i    (state_d == SERVE_GAME),
        .starved_o  (cnt_term)
    );

    assign starved = game_req_i && cnt_term;

    always_comb begin
        state_d = IDLE;
        if (starved) begin
            state_d = SERVE_GAME;
        end else if (vga_req_i) begin
            state_d = SERVE_VGA;
        end else if (game_req_i) begin
            state_d = SERVE_GAME;
        end
    end

    assign win_addr = (state_d == SERVE_GAME) ? game_addr_i : vga_addr_i;
    assign win_oor  = ({1'b0, win_addr} >= DEPTH_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            err0_q       <= 1'b0;
            tag_q        <= OWN_NONE;
            err_q        <= 1'b0;
            game_gnt_q   <= 1'b0;
            vga_miss_q   <= 1'b0;
            vga_valid_q  <= 1'b0;
            game_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            vga_data_q   <= '0;
            game_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            game_gnt_q <= (state_d == SERVE_GAME);
            vga_miss_q <= vga_req_i && starved;
            err0_q     <= (state_d != IDLE) && win_oor;
            if (state_d != IDLE) begin
                rom_addr_q <= win_addr;
            end
            // Tag stage travels alongside the ROM's own read register.
            tag_q <= owner_of(state_q);
            err_q <= err0_q;
            vga_valid_q  <= (tag_q == OWN_VGA);
            game_valid_q <= (tag_q == OWN_GAME);
            addr_err_q   <= err_q;
            if (tag_q == OWN_VGA) begin
                vga_data_q <= err_q ? '0 : rom_data_i;
            end
            if (tag_q == OWN_GAME) begin
                game_data_q <= err_q ? '0 : rom_data_i;
            end
        end
    end

    assign rom_addr_o   = rom_addr_q;
    assign game_gnt_o   = game_gnt_q;
    assign vga_miss_o   = vga_miss_q;
    assign vga_valid_o  = vga_valid_q;
    assign game_valid_o = game_valid_q;
    assign addr_err_o   = addr_err_q;
    assign vga_data_o   = vga_data_q;
    assign game_data_o  = game_data_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed and random stimulus for map_rom_arbiter, checked cycle by cycle
// against a transaction-level model of the arbitration rules.
module tb_map_rom_arbiter;

    localparam int WIDTH    = 30;
    localparam int DEPTH    = 21;
    localparam int ADDRW    = 5;
    localparam int MAX_WAIT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vga_req = 1'b0;
    logic [ADDRW-1:0] vga_addr = '0;
    logic             vga_valid, vga_miss;
    logic [WIDTH-1:0] vga_data;
    logic             game_req = 1'b0;
    logic [ADDRW-1:0] game_addr = '0;
    logic             game_gnt, game_valid, addr_err;
    logic [WIDTH-1:0] game_data;
    logic [ADDRW-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;

    logic [WIDTH-1:0] rom_mem [32];

    map_rom_arbiter #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDRW    (ADDRW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_req_i    (vga_req),
        .vga_addr_i   (vga_addr),
        .vga_valid_o  (vga_valid),
        .vga_data_o   (vga_data),
        .vga_miss_o   (vga_miss),
        .game_req_i   (game_req),
        .game_addr_i  (game_addr),
        .game_gnt_o   (game_gnt),
        .game_valid_o (game_valid),
        .game_data_o  (game_data),
        .addr_err_o   (addr_err),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data)
    );

    always #5 clk = ~clk;

    // External single-port ROM with one-cycle registered read.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // A read transaction as seen by the model: 0 none, 1 vga, 2 game.
    typedef struct {
        int owner;
        int addr;
    } rd_t;

    rd_t              p1, p2;
    int               m_wait;
    logic [WIDTH-1:0] m_vga_data, m_game_data;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] row_of(input int a);
        return (a < DEPTH) ? rom_mem[a] : '0;
    endfunction

    // One clock: predict from current inputs, advance, compare every output.
    task automatic cycle();
        rd_t cur, done;
        bit  miss;
        cur.owner = 0; cur.addr = 0;
        done.owner = 0; done.addr = 0;
        miss = 0;
        if (rst_n) begin
            if (game_req && m_wait == MAX_WAIT - 1) begin
                cur.owner = 2; cur.addr = int'(game_addr); miss = vga_req;
            end else if (vga_req) begin
                cur.owner = 1; cur.addr = int'(vga_addr);
            end else if (game_req) begin
                cur.owner = 2; cur.addr = int'(game_addr);
            end
            if (!game_req || cur.owner == 2) m_wait = 0;
            else if (m_wait < MAX_WAIT - 1) m_wait++;
            done = p2;
            p2 = p1;
            p1 = cur;
        end else begin
            m_wait = 0;
            p1 = done;
            p2 = done;
            m_vga_data = '0;
            m_game_data = '0;
        end
        if (done.owner == 1) m_vga_data = row_of(done.addr);
        if (done.owner == 2) m_game_data = row_of(done.addr);
        @(posedge clk);
        #1;
        $display("t=%0t req v=%0b/%0d g=%0b/%0d -> gnt=%0b miss=%0b vv=%0b gv=%0b err=%0b",
                 $time, vga_req, vga_addr, game_req, game_addr, game_gnt, vga_miss,
                 vga_valid, game_valid, addr_err);
        check_eq("game_gnt",   game_gnt,   cur.owner == 2);
        check_eq("vga_miss",   vga_miss,   miss);
        check_eq("vga_valid",  vga_valid,  done.owner == 1);
        check_eq("game_valid", game_valid, done.owner == 2);
        check_eq("addr_err",   addr_err,   done.owner != 0 && done.addr >= DEPTH);
        check_eq("vga_data",   vga_data,   m_vga_data);
        check_eq("game_data",  game_data,  m_game_data);
        if (game_gnt) game_req = 1'b0;
    endtask

    // Run cycles until game_gnt is seen (bounded) and check how many it took.
    task automatic wait_gnt(input string tag, input int exp_n);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            n++;
            if (game_gnt) got = 1;
        end
        check_eq(tag, n, exp_n);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = WIDTH'($urandom());
        p1.owner = 0; p1.addr = 0;
        p2 = p1;
        m_wait = 0;
        m_vga_data = '0;
        m_game_data = '0;

        // Reset held: requests toggle, everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            vga_req = i[0];
            game_req = i[1];
            vga_addr = ADDRW'($urandom_range(0, 31));
            game_addr = ADDRW'($urandom_range(0, 31));
            cycle();
            check_eq("rst_rom_addr", rom_addr, 0);
        end
        rst_n = 1'b1;
        game_req = 1'b0;
        vga_req = 1'b1;
        vga_addr = 5'd5;
        cycle();
        vga_req = 1'b0;
        cycle();
        cycle();
        check_eq("first_row5", vga_data, rom_mem[5]);

        // VGA streaming rows 0..20.
        for (int a = 0; a < DEPTH; a++) begin
            vga_req = 1'b1;
            vga_addr = ADDRW'(a);
            cycle();
        end
        vga_req = 1'b0;
        cycle();
        cycle();

        // Contention: VGA held, game must wait MAX_WAIT edges.
        vga_req = 1'b1;
        vga_addr = 5'd11;
        game_req = 1'b1;
        game_addr = 5'd7;
        wait_gnt("starve_wait", MAX_WAIT);
        for (int i = 0; i < 4; i++) begin
            vga_addr = ADDRW'(i);
            cycle();
        end
        check_eq("starve_row7", game_data, rom_mem[7]);
        vga_req = 1'b0;
        cycle();
        cycle();

        // Idle game requests, in range and out of range.
        game_req = 1'b1;
        game_addr = 5'd3;
        wait_gnt("idle_gnt", 1);
        cycle();
        cycle();
        game_req = 1'b1;
        game_addr = 5'd25;
        wait_gnt("oor_gnt", 1);
        cycle();
        cycle();

        // Reset one cycle after a grant: in-flight read must vanish.
        game_req = 1'b1;
        game_addr = 5'd9;
        wait_gnt("mid_gnt", 1);
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            vga_req = ($urandom_range(0, 3) != 0);
            vga_addr = ADDRW'($urandom_range(0, 31));
            if (!game_req && $urandom_range(0, 3) == 0) begin
                game_req = 1'b1;
                game_addr = ADDRW'($urandom_range(0, 31));
            end
            if (i % 500 == 250) rst_n = 1'b0;
            if (i % 500 == 253) rst_n = 1'b1;
            cycle();
        end
        vga_req = 1'b0;
        game_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
